sign_restorer_serial: RTL and testbench
=======================================

Name: sign_restorer_serial

Overview:
- Rebuilds a two's-complement word from an unsigned magnitude plus a sign bit. This is the reverse of the team's two's-complement negation converter.
- Sits after the sign-magnitude multiply path: magnitude product plus result sign go in, a signed product comes out.
- Processes CHUNK_W bits per cycle with a registered carry, so a narrow invert-and-add-one slice is reused over several beats.
- Valid/ready handshake on both sides.

Parameters:
- DATA_W, 32, width of magnitude input and signed output; must be an integer multiple of CHUNK_W.
- CHUNK_W, 8, bits converted per beat; BEATS = DATA_W/CHUNK_W (4 by default).

Ports:
- sys_clk  input  1  system clock; all state updates on the rising edge.
- sys_rst  input  1  asynchronous, active-high reset.
- mag_i  input  DATA_W  unsigned magnitude.
- sign_i  input  1  1 = result is negative.
- in_valid  input  1  mag_i/sign_i are valid.
- in_ready  output  1  block can accept a new operand.
- data_o  output  DATA_W  two's-complement result.
- ovf_o  output  1  magnitude is not representable in DATA_W-bit two's complement; valid with out_valid.
- out_valid  output  1  data_o/ovf_o are valid.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- Reset (async, sys_rst=1):
  - state=IDLE, beat counter=0, carry=0.
  - data_o=0, ovf_o=0, out_valid=0, in_ready=1.
  - Any conversion in flight is discarded, and no result is emitted for it.
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: capture mag_i, sign_i, carry<=sign_i, beat<=0, and ovf. Go to CONV.
  - ovf = ~sign_i & mag_i[DATA_W-1], or sign_i & mag_i[DATA_W-1] & |mag_i[DATA_W-2:0].
- CONV:
  - in_ready=0. Each cycle handles chunk k=beat, i.e. bits [k*CHUNK_W +: CHUNK_W].
  - sign=1: chunk_out = ~chunk + carry; carry <= carry-out of that add.
  - sign=0: chunk_out = chunk; carry stays 0.
  - chunk_out is written into the result register at the same position; beat increments.
  - After the beat with index BEATS-1, go to DONE.
- DONE:
  - out_valid=1; data_o and ovf_o held stable.
  - On out_ready: go to IDLE, out_valid=0 next cycle. in_ready rises in that same next cycle (no same-cycle turnaround).
- Latency: the handshake edge, then BEATS further edges. out_valid is high after the BEATS-th edge following capture (4 cycles by default).
- Throughput: one operation per BEATS+2 cycles when out_ready is held high.
- data_o is written only in CONV and is held unchanged in IDLE between operations.
- Boundary cases:
  - Zero magnitude with sign=1 gives 0, ovf=0; the final carry-out is dropped.
  - mag = 2^(DATA_W-1) with sign=1 gives 0x80000000, ovf=0.
  - The final beat's carry-out is always discarded.
  - in_valid asserted outside IDLE is ignored; the source must hold its data.
  - out_ready outside DONE is ignored.

Optional Feature:
- Macro: SIGN_RESTORER_SAT_EN.
- Defined: on entry to DONE with ovf=1, data_o is replaced by 0x7FFFFFFF (sign=0) or 0x80000000 (sign=1), i.e. the most positive or most negative DATA_W value. ovf_o is still asserted. Latency is unchanged.
- Undefined: data_o is the wrapped conversion result; ovf_o is informational only.

Test Plan:
- mag_i=0x00000005, sign_i=1, out_ready=1 -> out_valid 4 cycles after capture, data_o=0xFFFFFFFB, ovf_o=0.
- mag_i=0x00000000, sign_i=1 -> data_o=0x00000000, ovf_o=0; mag_i=0x12345678, sign_i=0 -> data_o=0x12345678.
- mag_i=0x80000000: sign_i=1 -> 0x80000000, ovf_o=0; sign_i=0 -> ovf_o=1, data_o=0x80000000 without the macro, 0x7FFFFFFF with it.
- mag_i=0x80000001, sign_i=1 -> ovf_o=1, data_o=0x7FFFFFFF without the macro, 0x80000000 with it.
- Result 0xFFFFFFFB with out_ready=0 for 10 cycles:
  - out_valid, data_o and ovf_o stay stable; in_ready=0 even with in_valid=1.
  - Release out_ready -> IDLE, in_ready=1 next cycle.
- Assert sys_rst during the 2nd CONV beat -> outputs return to reset values immediately with no clock edge needed, no out_valid pulse; the next operand converts correctly.

Source files
------------

// File: rtl/sign_restorer_serial.sv
// sign_restorer_serial
//   Rebuilds a two's-complement word from an unsigned magnitude plus a sign
//   bit, CHUNK_W bits per clock with a registered carry between beats
//   (invert-and-add-one for negative results, pass-through for positive ones).
//   One operand is converted every BEATS+2 cycles with out_ready held high.
//
//   Optional feature macro: SIGN_RESTORER_SAT_EN
//     defined   : an overflowing result is clamped to the most positive or
//                 most negative DATA_W value on entry to DONE (ovf_o still set)
//     undefined : data_o is the wrapped conversion, ovf_o is informational
//
// Parameters
//   DATA_W    width of magnitude input and signed output (multiple of CHUNK_W)
//   CHUNK_W   bits converted per beat
//
// Ports
//   sys_clk    in   clock, rising edge
//   sys_rst    in   asynchronous active-high reset
//   mag_i      in   unsigned magnitude
//   sign_i     in   1 = negative result
//   in_valid   in   mag_i/sign_i valid
//   in_ready   out  block can accept an operand (IDLE)
//   data_o     out  two's-complement result
//   ovf_o      out  magnitude not representable; valid with out_valid
//   out_valid  out  data_o/ovf_o valid (DONE)
//   out_ready  in   downstream accepts the result
module sign_restorer_serial #(
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 8
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [DATA_W-1:0]        mag_i,
  input  logic                     sign_i,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] data_o,
  output logic                     ovf_o,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int BEATS  = DATA_W / CHUNK_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              state, next_state;
  logic [BEAT_W-1:0]   beat;
  logic                carry;
  logic                sign_r;
  logic [DATA_W-1:0]   mag_r;
  logic [CHUNK_W-1:0]  chunk;
  logic [CHUNK_W-1:0]  chunk_out;
  logic                carry_nxt;
  logic                accept;
  logic                last_beat;

  // A negative zero magnitude (sign=1, mag=0) is fine; the only negative
  // value that fits with the top bit set is exactly -2^(DATA_W-1).
  function automatic logic calc_ovf(input logic [DATA_W-1:0] mag, input logic sign);
    calc_ovf = (~sign & mag[DATA_W-1]) |
               (sign & mag[DATA_W-1] & (|mag[DATA_W-2:0]));
  endfunction

`ifdef SIGN_RESTORER_SAT_EN
  function automatic logic signed [DATA_W-1:0] sat_value(input logic sign);
    sat_value = sign ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  endfunction
`endif

  assign accept    = in_valid & in_ready;
  assign last_beat = (beat == LAST_BEAT);

  // One chunk of invert-and-add-one; the carry chain is only CHUNK_W long.
  always_comb begin
    chunk = mag_r[beat*CHUNK_W +: CHUNK_W];
    if (sign_r) begin
      {carry_nxt, chunk_out} = {1'b0, ~chunk} + {{CHUNK_W{1'b0}}, carry};
    end else begin
      {carry_nxt, chunk_out} = {1'b0, chunk};
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = CONV;
      end
      CONV: begin
        if (last_beat) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Capture / conversion datapath
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      beat   <= '0;
      carry  <= 1'b0;
      sign_r <= 1'b0;
      ovf_o  <= 1'b0;
      data_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sign_r <= sign_i;
            carry  <= sign_i;
            beat   <= '0;
            ovf_o  <= calc_ovf(mag_i, sign_i);
          end
        end
        CONV: begin
          data_o[beat*CHUNK_W +: CHUNK_W] <= chunk_out;
          // The carry out of the final beat is dropped on the next capture.
          carry <= carry_nxt;
          beat  <= beat + 1'b1;
`ifdef SIGN_RESTORER_SAT_EN
          if (last_beat && ovf_o) data_o <= sat_value(sign_r);
`endif
        end
        default: ;
      endcase
    end
  end

  // Operand holding register; contents are meaningless until the next capture.
  always_ff @(posedge sys_clk) begin
    if (accept) mag_r <= mag_i;
  end

endmodule

// File: tb/tb_sign_restorer_serial.sv
module tb_sign_restorer_serial;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [31:0] mag_i = '0;
  logic        sign_i = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data_o;
  logic        ovf_o;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

`ifdef SIGN_RESTORER_SAT_EN
  localparam logic [31:0] EXP_POS_OVF = 32'h7FFFFFFF;
  localparam logic [31:0] EXP_NEG_OVF = 32'h80000000;
`else
  localparam logic [31:0] EXP_POS_OVF = 32'h80000000;
  localparam logic [31:0] EXP_NEG_OVF = 32'h7FFFFFFF;
`endif

  sign_restorer_serial #(.DATA_W(32), .CHUNK_W(8)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .mag_i    (mag_i),
    .sign_i   (sign_i),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_o   (data_o),
    .ovf_o    (ovf_o),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the block idle; returns at a negedge.
  // Leaves the block in DONE when out_ready is low.
  task automatic run_op(input string tag, input logic [31:0] mag, input logic sign,
                        input logic [31:0] exp_data, input logic exp_ovf);
    int cyc;
    mag_i    = mag;
    sign_i   = sign;
    in_valid = 1'b1;
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge sys_clk); #1;
      cyc++;
    end
    check({tag, ".latency"}, 32'(cyc), 32'd4);
    check({tag, ".data"}, data_o, exp_data);
    check({tag, ".ovf"}, {31'd0, ovf_o}, {31'd0, exp_ovf});
    if (out_ready) begin
      @(posedge sys_clk); #1;
      check({tag, ".ov_low"}, {31'd0, out_valid}, 32'd0);
      check({tag, ".ir_high"}, {31'd0, in_ready}, 32'd1);
      check({tag, ".held"}, data_o, exp_data);
    end
    @(negedge sys_clk);
  endtask

  initial begin
    int saw;
    #2;
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.data", data_o, 32'd0);
    check("rst.ovf", {31'd0, ovf_o}, 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    run_op("neg5",   32'h00000005, 1'b1, 32'hFFFFFFFB, 1'b0);
    run_op("negzero",32'h00000000, 1'b1, 32'h00000000, 1'b0);
    run_op("pos",    32'h12345678, 1'b0, 32'h12345678, 1'b0);
    run_op("carry",  32'h00000100, 1'b1, 32'hFFFFFF00, 1'b0);
    run_op("minneg", 32'h80000000, 1'b1, 32'h80000000, 1'b0);
    run_op("posovf", 32'h80000000, 1'b0, EXP_POS_OVF,  1'b1);
    run_op("negovf", 32'h80000001, 1'b1, EXP_NEG_OVF,  1'b1);

    // Downstream stall with a competing operand presented
    out_ready = 1'b0;
    run_op("stall", 32'h00000005, 1'b1, 32'hFFFFFFFB, 1'b0);
    mag_i    = 32'h0000_0077;
    sign_i   = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge sys_clk); #1;
      check("stall.ov", {31'd0, out_valid}, 32'd1);
      check("stall.data", data_o, 32'hFFFFFFFB);
      check("stall.ovf", {31'd0, ovf_o}, 32'd0);
      check("stall.ir", {31'd0, in_ready}, 32'd0);
    end
    @(negedge sys_clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge sys_clk); #1;
    check("release.ov", {31'd0, out_valid}, 32'd0);
    check("release.ir", {31'd0, in_ready}, 32'd1);
    check("release.held", data_o, 32'hFFFFFFFB);
    @(negedge sys_clk);

    // Asynchronous reset during the second conversion beat
    mag_i    = 32'h0000FF00;
    sign_i   = 1'b1;
    in_valid = 1'b1;
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    @(posedge sys_clk); #2;
    sys_rst = 1'b1;
    #1;
    check("arst.ov", {31'd0, out_valid}, 32'd0);
    check("arst.ir", {31'd0, in_ready}, 32'd1);
    check("arst.data", data_o, 32'd0);
    check("arst.ovf", {31'd0, ovf_o}, 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    saw = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge sys_clk); #1;
      if (out_valid) saw++;
    end
    check("arst.no_out", 32'(saw), 32'd0);
    @(negedge sys_clk);
    run_op("after_rst", 32'h0000FF00, 1'b1, 32'hFFFF0100, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
